// File: rtl/sme_match_collector.sv
// Result collector for the SME matcher: drops repeats of each pattern's last address, buffers
// unique results in a FIFO for the host, keeps statistics and reports done once drained.
module sme_match_collector #(
   parameter int PW    = 4,
   parameter int MW    = 12,
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CW    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [PW-1:0]    pattern_no,
   input  logic [MW-1:0]    match_addr,
   input  logic             finish,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW+MW-1:0] out_data,
   output logic [CW-1:0]    uniq_cnt,
   output logic [CW-1:0]    dup_cnt,
   output logic [CW-1:0]    ovf_cnt,
   output logic             overflow,
   output logic             done
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t             state;
   logic [PW+MW-1:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic [2**PW-1:0]   seen;
   logic [MW-1:0]      last_addr [2**PW];
   logic               take, dup, full, pop, push, lost;

   // All table-driven decisions are gated by take, so X on the data bus while idle is harmless.
   always_comb begin
      take      = valid && (state == S_RUN);
      dup       = seen[pattern_no] && (last_addr[pattern_no] == match_addr);
      full      = (count == FULL_CNT);
      out_valid = (count != '0);
      pop       = out_valid && out_ready;
      push      = take && !dup && (!full || pop);
      lost      = take && !dup && full && !pop;
      out_data  = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {pattern_no, match_addr};
      if (take && !dup)
         last_addr[pattern_no] <= match_addr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_RUN;
         done     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         seen     <= '0;
         uniq_cnt <= '0;
         dup_cnt  <= '0;
         ovf_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (take) begin
            if (dup) begin
               if (dup_cnt != '1)
                  dup_cnt <= dup_cnt + 1'b1;
            end else begin
               seen[pattern_no] <= 1'b1;
            end
         end
         if (push && uniq_cnt != '1)
            uniq_cnt <= uniq_cnt + 1'b1;
         if (lost) begin
            overflow <= 1'b1;
            if (ovf_cnt != '1)
               ovf_cnt <= ovf_cnt + 1'b1;
         end

         case (state)
            S_RUN:   if (finish) state <= S_DRAIN;
            S_DRAIN: if (count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
            S_DONE:  state <= S_DONE;
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_sme_match_collector.sv
// Directed and randomized bench for sme_match_collector against a queue-based reference model.
module tb_sme_match_collector;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [3:0]  pattern_no = '0;
   logic [11:0] match_addr = '0;
   logic        finish = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_data;
   logic [15:0] uniq_cnt, dup_cnt, ovf_cnt;
   logic        overflow, done;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] q[$];
   bit          seen_m [16];
   logic [11:0] last_m [16];
   int          uniq_m, dup_m, ovf_m;
   bit          ovfl_m;
   int          mode_m;  // 0 run, 1 drain, 2 done

   sme_match_collector #(.PW(4), .MW(12), .DEPTH(16), .AW(4), .CW(16)) dut (
      .clk(clk), .reset(reset), .valid(valid), .pattern_no(pattern_no),
      .match_addr(match_addr), .finish(finish), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .uniq_cnt(uniq_cnt),
      .dup_cnt(dup_cnt), .ovf_cnt(ovf_cnt), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_clear();
      q.delete();
      for (int i = 0; i < 16; i++) seen_m[i] = 0;
      uniq_m = 0; dup_m = 0; ovf_m = 0; ovfl_m = 0; mode_m = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_oval"}, 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk({tag, "_odata"}, 32'(out_data), 32'(q[0]));
      chk({tag, "_uniq"}, 32'(uniq_cnt), uniq_m);
      chk({tag, "_dup"}, 32'(dup_cnt), dup_m);
      chk({tag, "_ovf"}, 32'(ovf_cnt), ovf_m);
      chk({tag, "_ovfl"}, 32'(overflow), 32'(ovfl_m));
      chk({tag, "_done"}, 32'(done), 32'(mode_m == 2));
   endtask

   // One clock: drive inputs, advance the model by the documented rules, compare after the edge.
   task automatic step(input string tag, input bit v, input logic [3:0] p, input logic [11:0] a,
                       input bit fin, input bit rdy);
      int  pre;
      bit  pop;
      valid = v; finish = fin; out_ready = rdy;
      pattern_no = v ? p : 'x;
      match_addr = v ? a : 'x;
      @(posedge clk);
      pre = q.size();
      pop = (pre != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (mode_m == 0 && v) begin
         if (seen_m[p] && last_m[p] == a) dup_m = sat(dup_m);
         else begin
            seen_m[p] = 1; last_m[p] = a;
            if (pre < 16 || pop) begin q.push_back({p, a}); uniq_m = sat(uniq_m); end
            else begin ovf_m = sat(ovf_m); ovfl_m = 1; end
         end
      end
      if (mode_m == 0 && fin) mode_m = 1;
      else if (mode_m == 1 && pre == 0) mode_m = 2;
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(tag, 0, '0, '0, 0, rdy);
   endtask

   task automatic apply_reset(input string tag);
      #2;
      reset = 1'b1; valid = 1'b0; finish = 1'b0;
      #1;
      chk({tag, "_oval"}, 32'(out_valid), 0);
      chk({tag, "_uniq"}, 32'(uniq_cnt), 0);
      chk({tag, "_dup"}, 32'(dup_cnt), 0);
      chk({tag, "_ovf"}, 32'(ovf_cnt), 0);
      chk({tag, "_ovfl"}, 32'(overflow), 0);
      chk({tag, "_done"}, 32'(done), 0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      model_clear();
      apply_reset("rst0");

      // basic capture and ordering
      step("t1a", 1, 4'd1, 12'h005, 0, 1);
      chk("t1_head0", 32'(out_data), 32'h1005);
      step("t1b", 1, 4'd2, 12'h010, 0, 1);
      chk("t1_head1", 32'(out_data), 32'h2010);
      idle("t1i", 2, 1);
      chk("t1_uniq", 32'(uniq_cnt), 2);
      chk("t1_dup", 32'(dup_cnt), 0);

      // back-to-back repeat is dropped; return to an older address is unique again
      step("t2a", 1, 4'd3, 12'h0AB, 0, 1);
      step("t2b", 1, 4'd3, 12'h0AB, 0, 1);
      step("t2c", 1, 4'd3, 12'h0AC, 0, 1);
      step("t2d", 1, 4'd3, 12'h0AB, 0, 1);
      idle("t2i", 3, 1);
      chk("t2_dup", 32'(dup_cnt), 1);
      chk("t2_uniq", 32'(uniq_cnt), 5);

      // fill past capacity with the consumer stalled
      for (int i = 0; i < 17; i++) step("t3f", 1, 4'd5, 12'(i), 0, 0);
      chk("t3_ovf", 32'(ovf_cnt), 1);
      chk("t3_ovfl", 32'(overflow), 1);
      chk("t3_head", 32'(out_data), 32'h5000);

      // full FIFO: simultaneous push and pop is accepted, then one more push is lost
      step("t4a", 1, 4'd6, 12'h123, 0, 1);
      chk("t4_ovf_same", 32'(ovf_cnt), 1);
      step("t4b", 1, 4'd6, 12'h124, 0, 0);
      chk("t4_ovf_full", 32'(ovf_cnt), 2);
      step("t4c", 1, 4'd6, 12'h124, 0, 0);
      chk("t4_dup_lost", 32'(dup_cnt), 2);
      idle("t3d", 20, 1);
      chk("t3_empty", 32'(out_valid), 0);

      // randomized traffic over a small key space to exercise dups, stalls and overflow
      for (int i = 0; i < 400; i++) begin
         bit          v   = ($urandom_range(0, 3) != 0);
         logic [3:0]  p   = 4'($urandom_range(0, 3));
         logic [11:0] a   = 12'($urandom_range(0, 3));
         bit          rdy = ($urandom_range(0, 2) == 0);
         step("rnd", v, p, a, 0, rdy);
      end
      idle("rndd", 20, 1);

      // reset in the middle of a stream
      for (int i = 0; i < 5; i++) step("t6f", 1, 4'd7, 12'h070 + 12'(i), 0, 0);
      chk("t6_before", 32'(out_valid), 1);
      apply_reset("t6rst");
      step("t6re", 1, 4'd7, 12'h074, 0, 0);
      chk("t6_re_uniq", 32'(uniq_cnt), 1);
      chk("t6_re_dup", 32'(dup_cnt), 0);
      idle("t6d", 2, 1);

      // finish together with a final result
      step("t5a", 1, 4'd4, 12'hFFF, 1, 1);
      chk("t5_head", 32'(out_data), 32'h4FFF);
      idle("t5w", 4, 1);
      chk("t5_done", 32'(done), 1);
      step("t5x", 1, 4'd9, 12'h001, 1, 1);
      step("t5y", 1, 4'd9, 12'h002, 0, 1);
      chk("t5_uniq_frozen", 32'(uniq_cnt), 2);
      chk("t5_oval", 32'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
